// File: rtl/kmeans_iter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_iter_ctrl_if
//  Purpose  : Bundles the run-control, datapath handshake and centroid buses
//             of the k-means iteration controller.
//  Modports : master - run requester / assignment+update datapath side
//                      (drives start, abort, init_c, assign_done,
//                      update_done, new_c)
//             slave  - the controller (drives cent_c, assign_go, update_go,
//                      busy, done, converged, iter_cnt)
//  Revision : 1.0 - initial release
// ============================================================================
interface kmeans_iter_ctrl_if #(
   parameter int K  = 8,
   parameter int D  = 4,
   parameter int W  = 8,
   parameter int IW = 8
);
   logic                      start;
   logic                      abort;
   logic signed [K*D*W-1:0]   init_c;
   logic signed [K*D*W-1:0]   cent_c;
   logic                      assign_go;
   logic                      assign_done;
   logic                      update_go;
   logic                      update_done;
   logic signed [K*D*W-1:0]   new_c;
   logic                      busy;
   logic                      done;
   logic                      converged;
   logic [IW-1:0]             iter_cnt;

   modport master (
      output start, abort, init_c, assign_done, update_done, new_c,
      input  cent_c, assign_go, update_go, busy, done, converged, iter_cnt
   );

   modport slave (
      input  start, abort, init_c, assign_done, update_done, new_c,
      output cent_c, assign_go, update_go, busy, done, converged, iter_cnt
   );
endinterface
`default_nettype wire

// File: rtl/kmeans_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_iter_ctrl
//  Purpose  : Sequences k-means clustering iterations: launches the
//             assignment pass, then the centroid-update pass, compares the
//             recomputed centroids with the current ones and repeats until
//             they are identical or MAX_ITER iterations have completed.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - kmeans_iter_ctrl_if.slave (start/abort, centroid buses,
//                    go/done handshakes, busy/done/converged/iter_cnt status)
//  Revision : 1.0 - initial release
// ============================================================================
module kmeans_iter_ctrl #(
   parameter int K        = 8,
   parameter int D        = 4,
   parameter int W        = 8,
   parameter int MAX_ITER = 16,
   parameter int IW       = 8
) (
   input  wire                   clk,
   input  wire                   rst,
   kmeans_iter_ctrl_if.slave     bus
);

   localparam int            C_CW      = K * D * W;
   localparam logic [IW-1:0] C_MAX_IT  = IW'(MAX_ITER);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LAUNCH_A = 3'd1;
   localparam logic [2:0] S_WAIT_A   = 3'd2;
   localparam logic [2:0] S_LAUNCH_U = 3'd3;
   localparam logic [2:0] S_WAIT_U   = 3'd4;
   localparam logic [2:0] S_CHECK    = 3'd5;
   localparam logic [2:0] S_FIN      = 3'd6;

   // The iteration counter must be able to reach MAX_ITER without wrapping.
   generate
      if (MAX_ITER < 1 || longint'(MAX_ITER) > ((longint'(1) << IW) - 1)) begin : g_bad_max_iter
         $error("kmeans_iter_ctrl: MAX_ITER must be in 1 .. 2**IW-1");
      end
   endgenerate

   logic [2:0]              state_q, state_d;
   logic signed [C_CW-1:0]  cent_q, cent_d;
   logic signed [C_CW-1:0]  nc_q, nc_d;
   logic [IW-1:0]           iter_q, iter_d;
   logic                    conv_q, conv_d;
   logic [IW-1:0]           w_iter_inc;
   logic                    w_eq;
   logic                    w_abort;

   assign w_iter_inc = iter_q + 1'b1;
   assign w_eq       = (cent_q == nc_q);
   // abort is meaningless in IDLE, so start always wins there.
   assign w_abort    = bus.abort && (state_q != S_IDLE);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cent_q  <= '0;
         nc_q    <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cent_q  <= cent_d;
         nc_q    <= nc_d;
         iter_q  <= iter_d;
         conv_q  <= conv_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      if (w_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:     if (bus.start) state_d = S_LAUNCH_A;
            S_LAUNCH_A: state_d = S_WAIT_A;
            S_WAIT_A:   if (bus.assign_done) state_d = S_LAUNCH_U;
            S_LAUNCH_U: state_d = S_WAIT_U;
            S_WAIT_U:   if (bus.update_done) state_d = S_CHECK;
            S_CHECK:    state_d = (w_eq || w_iter_inc == C_MAX_IT) ? S_FIN : S_LAUNCH_A;
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------ datapath update
   // An abort freezes centroids and count; only the result flag is cleared.
   always_comb begin
      cent_d = cent_q;
      nc_d   = nc_q;
      iter_d = iter_q;
      conv_d = conv_q;
      if (w_abort) begin
         conv_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  cent_d = bus.init_c;
                  iter_d = '0;
                  conv_d = 1'b0;
               end
            end
            S_WAIT_U: begin
               if (bus.update_done) nc_d = bus.new_c;
            end
            S_CHECK: begin
               cent_d = nc_q;
               iter_d = w_iter_inc;
               // Equality beats the iteration limit when both hold.
               conv_d = w_eq;
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      bus.assign_go = (state_q == S_LAUNCH_A);
      bus.update_go = (state_q == S_LAUNCH_U);
      bus.done      = (state_q == S_FIN);
      bus.busy      = (state_q != S_IDLE);
   end

   assign bus.cent_c    = cent_q;
   assign bus.iter_cnt  = iter_q;
   assign bus.converged = conv_q;

endmodule
`default_nettype wire

// File: tb/tb_kmeans_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kmeans_iter_ctrl
//  Purpose  : Self-checking bench for kmeans_iter_ctrl (K=2, D=2, W=8,
//             MAX_ITER=4). Acts as the assignment/update datapath, drives
//             table-driven clustering runs and checks results via a
//             scoreboard queue, plus abort/reset/stray-strobe sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kmeans_iter_ctrl;

   localparam int C_K = 2, C_D = 2, C_W = 8, C_MAX = 4, C_IW = 8;

   typedef struct packed {
      logic [31:0]       init;
      logic [3:0][31:0]  nc;
      logic [7:0]        aw;
      logic [7:0]        uw;
      logic              stray;
      logic              exp_conv;
      logic [7:0]        exp_iter;
      logic [31:0]       exp_cent;
   } vec_t;

   typedef struct packed {
      logic        conv;
      logic [7:0]  iter;
      logic [31:0] cent;
      logic [15:0] lat;
      logic [7:0]  n_as;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[5];
   exp_t sbq[$];

   always #5 clk = ~clk;

   kmeans_iter_ctrl_if #(.K(C_K), .D(C_D), .W(C_W), .IW(C_IW)) bus ();

   kmeans_iter_ctrl #(.K(C_K), .D(C_D), .W(C_W), .MAX_ITER(C_MAX), .IW(C_IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {a[7:0], b[7:0], c[7:0], d[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Waits (bounded) until the selected strobe is high: 0=assign_go 1=update_go.
   task automatic wait_go(input int sel, input string name);
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         if ((sel == 0) ? bus.assign_go : bus.update_go) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk(name, ok, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"},  bus.busy,      0);
      chk({tag, "_done"},  bus.done,      0);
      chk({tag, "_ago"},   bus.assign_go, 0);
      chk({tag, "_ugo"},   bus.update_go, 0);
      chk({tag, "_conv"},  bus.converged, 0);
      chk({tag, "_iter"},  bus.iter_cnt,  0);
      chk({tag, "_cent"},  bus.cent_c,    0);
   endtask

   // Runs one table record with the bench acting as the datapath.
   task automatic run_vec(input int idx);
      vec_t v;
      exp_t e;
      exp_t got_e;
      int   cyc, n_as, it, a_tmr, u_tmr;
      bit   stray_pend, excl_ok, got;
      v      = vecs[idx];
      e.conv = v.exp_conv;
      e.iter = v.exp_iter;
      e.cent = v.exp_cent;
      e.lat  = 16'(1 + int'(v.exp_iter) * (int'(v.aw) + int'(v.uw) + 5));
      e.n_as = v.exp_iter;
      sbq.push_back(e);

      bus.init_c = v.init;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      bus.init_c = pk(99, 99, 99, 99);
      cyc = 1; n_as = 0; it = 0; a_tmr = 0; u_tmr = 0;
      stray_pend = 0; excl_ok = 1; got = 0;
      while (cyc < 400 && !got) begin
         bus.assign_done = 1'b0;
         bus.update_done = 1'b0;
         bus.start       = 1'b0;
         if (int'(bus.assign_go) + int'(bus.update_go) + int'(bus.done) > 1) excl_ok = 0;
         if (a_tmr > 0) begin
            a_tmr--;
            if (a_tmr == 0) bus.assign_done = 1'b1;
         end
         if (u_tmr > 0) begin
            u_tmr--;
            if (u_tmr == 0) begin
               bus.update_done = 1'b1;
               bus.new_c       = (it < 4) ? v.nc[it] : 32'h0;
               it++;
            end
         end
         if (stray_pend) begin
            stray_pend      = 0;
            bus.update_done = 1'b1;
            bus.start       = 1'b1;
            bus.new_c       = 32'hDEADBEEF;
         end
         if (bus.assign_go) begin
            n_as++;
            a_tmr = int'(v.aw) + 1;
            if (v.stray && n_as == 1) stray_pend = 1;
         end
         if (bus.update_go) u_tmr = int'(v.uw) + 1;
         if (bus.done) begin
            got = 1;
         end else begin
            tick();
            cyc++;
         end
      end
      bus.assign_done = 1'b0;
      bus.update_done = 1'b0;
      bus.start       = 1'b0;
      chk($sformatf("v%0d_done_seen", idx), got, 1);
      got_e = sbq.pop_front();
      if (got) begin
         chk($sformatf("v%0d_conv", idx),    bus.converged, got_e.conv);
         chk($sformatf("v%0d_iter", idx),    bus.iter_cnt,  got_e.iter);
         chk($sformatf("v%0d_cent", idx),    bus.cent_c,    got_e.cent);
         chk($sformatf("v%0d_latency", idx), cyc,           got_e.lat);
         chk($sformatf("v%0d_nassign", idx), n_as,          got_e.n_as);
         chk($sformatf("v%0d_exclusive", idx), excl_ok,     1);
         tick();
         chk($sformatf("v%0d_done_1cyc", idx), bus.done, 0);
         chk($sformatf("v%0d_busy_after", idx), bus.busy, 0);
         chk($sformatf("v%0d_conv_held", idx), bus.converged, got_e.conv);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      // {init, nc[3..0], aw, uw, stray, exp_conv, exp_iter, exp_cent}
      vecs[0] = '{pk(1,2,3,4), {32'h0, 32'h0, pk(5,5,6,6), pk(5,5,6,6)},
                  8'd0, 8'd0, 1'b0, 1'b1, 8'd2, pk(5,5,6,6)};
      vecs[1] = '{pk(1,1,1,1), {pk(5,5,5,5), pk(4,4,4,4), pk(3,3,3,3), pk(2,2,2,2)},
                  8'd2, 8'd1, 1'b0, 1'b0, 8'd4, pk(5,5,5,5)};
      vecs[2] = '{pk(9,9,9,9), {pk(3,3,3,3), pk(3,3,3,3), pk(2,2,2,2), pk(1,1,1,1)},
                  8'd1, 8'd0, 1'b0, 1'b1, 8'd4, pk(3,3,3,3)};
      vecs[3] = '{pk(7,-1,0,3), {32'h0, 32'h0, 32'h0, pk(7,-1,0,3)},
                  8'd0, 8'd3, 1'b0, 1'b1, 8'd1, pk(7,-1,0,3)};
      vecs[4] = '{pk(10,20,30,40), {32'h0, pk(12,22,32,42), pk(12,22,32,42), pk(11,21,31,41)},
                  8'd2, 8'd1, 1'b1, 1'b1, 8'd3, pk(12,22,32,42)};

      bus.start = 1'b0; bus.abort = 1'b0; bus.init_c = '0;
      bus.assign_done = 1'b0; bus.update_done = 1'b0; bus.new_c = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_reset_vals("reset");

      for (int i = 0; i < 5; i++) run_vec(i);

      // Abort in WAIT_U of iteration 2, same cycle as update_done.
      bus.init_c = pk(1,2,3,4);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      wait_go(0, "ab_ago1");
      tick(); bus.assign_done = 1'b1; tick(); bus.assign_done = 1'b0;
      wait_go(1, "ab_ugo1");
      tick(); bus.update_done = 1'b1; bus.new_c = pk(4,4,4,4); tick(); bus.update_done = 1'b0;
      wait_go(0, "ab_ago2");
      tick(); bus.assign_done = 1'b1; tick(); bus.assign_done = 1'b0;
      wait_go(1, "ab_ugo2");
      tick(); bus.update_done = 1'b1; bus.abort = 1'b1; bus.new_c = pk(8,8,8,8);
      tick(); bus.update_done = 1'b0; bus.abort = 1'b0;
      chk("ab_busy", bus.busy, 0);
      chk("ab_conv", bus.converged, 0);
      chk("ab_cent", bus.cent_c, pk(4,4,4,4));
      chk("ab_iter", bus.iter_cnt, 1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done || bus.busy) seen = 1;
         tick();
      end
      chk("ab_no_done", seen, 0);

      // start and abort together in IDLE: start wins; abort later returns to IDLE.
      bus.init_c = pk(2,2,2,2);
      bus.start = 1'b1; bus.abort = 1'b1; tick(); bus.start = 1'b0; bus.abort = 1'b0;
      chk("sa_busy", bus.busy, 1);
      chk("sa_ago", bus.assign_go, 1);
      chk("sa_cent", bus.cent_c, pk(2,2,2,2));
      tick();
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      chk("sa_abort_idle", bus.busy, 0);
      chk("sa_abort_nodone", bus.done, 0);

      // Reset held two cycles during WAIT_A, then a clean run.
      bus.init_c = pk(3,3,3,3);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      wait_go(0, "rs_ago");
      tick();
      rst = 1'b1; bus.assign_done = 1'b1; tick(); tick(); rst = 1'b0; bus.assign_done = 1'b0;
      check_reset_vals("midrst");
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done || bus.busy) seen = 1;
         tick();
      end
      chk("rs_no_done", seen, 0);
      run_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
